// File: rtl/latch_shift_chain.sv
// latch_shift_chain: latch shift register driven by its own non-overlapping two-phase clocks.
// Each accepted step loads or recirculates one word and advances the chain by one position.
module latch_shift_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 128,
  parameter int GAP   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     mode,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  output logic [$clog2(DEPTH/2+1)-1:0]   fill,
  output logic                           ph1,
  output logic                           ph2
);
  localparam int POS = DEPTH / 2;
  localparam int FW  = $clog2(POS + 1);

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_GAP1, S_PH2, S_GAP2} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_cnt;
  logic             r_ph1, r_ph2, r_shift, r_valid;
  logic [WIDTH-1:0] r_head;
  logic [FW-1:0]    r_fill, w_fill_next;
  logic             w_accept, w_in_gap, w_gap_done, w_step_end;

  assign in_ready    = (r_state == S_IDLE) && !mode[1];
  assign w_accept    = in_valid && in_ready;
  assign w_in_gap    = (r_state == S_GAP1) || (r_state == S_GAP2);
  assign w_gap_done  = r_cnt == 4'(GAP - 1);
  assign w_step_end  = (r_state != S_IDLE) && (w_next == S_IDLE);
  assign w_fill_next = (r_shift && r_fill != FW'(POS)) ? r_fill + FW'(1) : r_fill;
  assign ph1         = r_ph1;
  assign ph2         = r_ph2;
  assign fill        = r_fill;
  assign out_valid   = r_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_accept ? S_PH1 : S_IDLE;
      S_PH1:   w_next = (GAP == 0) ? S_PH2 : S_GAP1;
      S_GAP1:  w_next = w_gap_done ? S_PH2 : S_GAP1;
      S_PH2:   w_next = (GAP == 0) ? S_IDLE : S_GAP2;
      S_GAP2:  w_next = w_gap_done ? S_IDLE : S_GAP2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  // Phases are registered from the next state so they never glitch or overlap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ph1   <= 1'b0;
      r_ph2   <= 1'b0;
      r_head  <= '0;
      r_shift <= 1'b0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_cnt   <= (w_in_gap && !w_gap_done) ? r_cnt + 4'd1 : 4'd0;
      r_ph1   <= w_next == S_PH1;
      r_ph2   <= w_next == S_PH2;
      r_valid <= w_step_end && (w_fill_next == FW'(POS));
      if (w_accept) begin
        r_head  <= mode[0] ? out_data : in_data;
        r_shift <= !mode[0];
      end
      if (w_step_end) r_fill <= w_fill_next;
    end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] r_q, w_d;
    logic             w_en;
    if (i == 0) begin : g_first
      assign w_d = r_head;
    end else begin : g_next
      assign w_d = g_stage[i-1].r_q;
    end
    assign w_en = (i % 2 == 0) ? r_ph1 : r_ph2;
    always_latch
      if (!rst_n)    r_q <= '0;
      else if (w_en) r_q <= w_d;
  end

  assign out_data = g_stage[DEPTH-1].r_q;
endmodule

// File: tb/tb_latch_shift_chain.sv
// tb_latch_shift_chain: scoreboard bench for the two-phase latch shift chain.
module tb_latch_shift_chain;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [1:0] mode = '0;
  logic       in_ready, out_valid, ph1, ph2;
  logic [7:0] out_data;
  logic [2:0] fill;

  logic       gv[2], gd[2], gr[2], go[2], gov[2], gf[2], gp1[2], gp2[2];
  logic [1:0] gm[2];

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pos[4];
  int         m_fill;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  latch_shift_chain #(.WIDTH(8), .DEPTH(8), .GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .out_data(out_data), .out_valid(out_valid), .fill(fill), .ph1(ph1), .ph2(ph2));

  latch_shift_chain #(.WIDTH(1), .DEPTH(2), .GAP(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .in_data(gd[0]), .in_valid(gv[0]), .in_ready(gr[0]),
    .mode(gm[0]), .out_data(go[0]), .out_valid(gov[0]), .fill(gf[0]), .ph1(gp1[0]), .ph2(gp2[0]));

  latch_shift_chain #(.WIDTH(1), .DEPTH(2), .GAP(3)) u_g3 (
    .clk(clk), .rst_n(rst_n), .in_data(gd[1]), .in_valid(gv[1]), .in_ready(gr[1]),
    .mode(gm[1]), .out_data(go[1]), .out_valid(gov[1]), .fill(gf[1]), .ph1(gp1[1]), .ph2(gp2[1]));

  task automatic model_reset();
    foreach (m_pos[i]) m_pos[i] = '0;
    m_fill = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL %s out_data got %h want 00", tag, out_data); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL %s fill got %0d want 0", tag, fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid got %b want 0", tag, out_valid); end
    checks++; if ({ph1, ph2} !== 2'b00) begin errors++; $display("FAIL %s ph1/ph2 got %b%b want 00", tag, ph1, ph2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b want 1", tag, in_ready); end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic do_step(input logic [1:0] m, input logic [7:0] d);
    logic [7:0]  tail;
    logic [15:0] a1, a2;
    int          low;
    bit          both;
    mode = m; in_data = d; in_valid = 1'b1;
    tail = m_pos[3];
    for (int i = 3; i > 0; i--) m_pos[i] = m_pos[i-1];
    m_pos[0] = m[0] ? tail : d;
    if (!m[0] && m_fill < 4) m_fill++;
    if (m_fill == 4) exp_q.push_back(m_pos[3]);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL step_ready_pre got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d; mode = {1'b0, ~m[0]};
    a1 = '0; a2 = '0; low = 0; both = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      a1[c] = ph1; a2[c] = ph2;
      if (ph1 && ph2) both = 1;
      if (in_ready) break;
      low++;
    end
    checks++; if (low != 4) begin errors++; $display("FAIL step_busy_cycles got %0d want 4", low); end
    checks++; if (a1 !== 16'h0002) begin errors++; $display("FAIL step_ph1_cycles got %h want 0002", a1); end
    checks++; if (a2 !== 16'h0008) begin errors++; $display("FAIL step_ph2_cycles got %h want 0008", a2); end
    checks++; if (both) begin errors++; $display("FAIL step_phase_overlap got 1 want 0"); end
    checks++;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin errors++; $display("FAIL step_out_valid got 1 want 0"); end
      else begin
        tail = exp_q.pop_front();
        if (out_data !== tail) begin errors++; $display("FAIL step_out_word got %h want %h", out_data, tail); end
      end
    end else if (exp_q.size() != 0) begin
      tail = exp_q.pop_front();
      errors++; $display("FAIL step_out_valid got %b want 1 (word %h)", out_valid, tail);
    end
    checks++; if (fill !== 3'(m_fill)) begin errors++; $display("FAIL step_fill got %0d want %0d", fill, m_fill); end
    checks++; if (out_data !== m_pos[3]) begin errors++; $display("FAIL step_out_data got %h want %h", out_data, m_pos[3]); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_fill_back_to_back();
    do_step(2'b00, 8'h11);
    do_step(2'b00, 8'h22);
    do_step(2'b00, 8'h33);
    do_step(2'b00, 8'h44);
  endtask

  task automatic test_recirculate();
    for (int i = 0; i < 4; i++) do_step(2'b01, 8'h00);
  endtask

  task automatic test_hold();
    logic [7:0] d0;
    logic [2:0] f0;
    d0 = out_data; f0 = fill;
    mode = 2'b10; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || ph1 !== 1'b0 || ph2 !== 1'b0 || out_data !== d0 || fill !== f0) begin
        errors++;
        $display("FAIL hold cycle %0d got rdy=%b ph=%b%b data=%h fill=%0d want rdy=0 ph=00 data=%h fill=%0d",
                 c, in_ready, ph1, ph2, out_data, fill, d0, f0);
      end
    end
    in_valid = 1'b0;
    do_step(2'b00, 8'h55);
  endtask

  task automatic test_phase_timing();
    logic [15:0] a1, a2;
    int          g, rdy;
    bit          both;
    for (int k = 0; k < 2; k++) begin
      g = (k == 0) ? 0 : 3;
      a1 = '0; a2 = '0; rdy = -1; both = 0;
      @(negedge clk);
      gm[k] = 2'b00; gv[k] = 1'b1;
      @(posedge clk); #1;
      gv[k] = 1'b0;
      for (int c = 1; c <= 15; c++) begin
        @(negedge clk);
        a1[c] = gp1[k]; a2[c] = gp2[k];
        if (gp1[k] && gp2[k]) both = 1;
        if (rdy < 0 && gr[k]) rdy = c;
      end
      checks++; if (a1 !== 16'h0002) begin errors++; $display("FAIL phase_ph1 gap=%0d got %h want 0002", g, a1); end
      checks++; if (a2 !== (16'd1 << (2 + g))) begin errors++; $display("FAIL phase_ph2 gap=%0d got %h want %h", g, a2, 16'd1 << (2 + g)); end
      checks++; if (rdy != 3 + 2 * g) begin errors++; $display("FAIL phase_idle gap=%0d got %0d want %0d", g, rdy, 3 + 2 * g); end
      checks++; if (both) begin errors++; $display("FAIL phase_overlap gap=%0d got 1 want 0", g); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found;
    do_step(2'b00, 8'h61);
    do_step(2'b00, 8'h62);
    mode = 2'b00; in_data = 8'h63; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ph2) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_mid_ph2 got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_step(2'b00, 8'hA1);
    do_step(2'b00, 8'hA2);
    do_step(2'b00, 8'hA3);
    do_step(2'b00, 8'hA4);
    checks++; if (out_data !== 8'hA1) begin errors++; $display("FAIL reset_mid_first_word got %h want a1", out_data); end
  endtask

  initial begin
    foreach (gv[i]) begin gv[i] = 1'b0; gd[i] = 1'b0; gm[i] = 2'b00; end
    test_reset();
    test_fill_back_to_back();
    test_recirculate();
    test_hold();
    test_phase_timing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/latch_shift_chain.md
# latch_shift_chain

Parametrised latch-based shift register with built-in non-overlapping two-phase clock generation, WIDTH-bit lanes and DEPTH latch stages. Each accepted request performs one shift step (ph1 pulse, gap, ph2 pulse, gap), either loading a new word or recirculating the tail word to the head. It sits directly behind the tile I/O as the next-generation latch storage experiment, adding a valid/ready handshake, a recirculate/hold mode and an occupancy count.

## Interface
- WIDTH, 1: bits per stage (lane count), ≥1.
- DEPTH, 128: latch stages, even, ≥2; POS = DEPTH/2 word positions.
- GAP, 1: idle clk cycles between phase pulses, 0..15.
- clk  in  1  system clock; all control logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  word to shift in (shift mode only).
- in_valid  in  1  step request.
- in_ready  out  1  high when a step can be accepted.
- mode  in  2  00 shift, 01 recirculate, 10/11 hold; sampled only at acceptance.
- out_data  out  WIDTH  output of latch stage DEPTH-1 (continuous).
- out_valid  out  1  one-cycle pulse: step done and chain full.
- fill  out  clog2(POS+1)  words written since reset, saturating at POS.
- ph1, ph2  out  1  registered phase clocks (debug visibility).

## Operation
- Latch stage i is transparent while its phase is high: even i on ph1, odd i on ph2. Stage 0 D = head register; stage i D = stage i-1 Q. Every latch clears asynchronously while rst_n=0.
- ph1/ph2 are flop outputs, never combinational; ph1&ph2 is never 1.
- FSM states: IDLE, PH1, GAP1, PH2, GAP2.
- IDLE: in_ready = (mode is 00 or 01). On in_valid&in_ready: head register <= in_data (mode 00) or out_data (mode 01); mode latched; -> PH1.
- PH1: ph1=1 one cycle; -> GAP1 (or PH2 if GAP=0).
- GAP1: GAP cycles, both phases low; -> PH2.
- PH2: ph2=1 one cycle; -> GAP2 (or IDLE if GAP=0).
- GAP2: GAP cycles; -> IDLE.
- On entry to IDLE after a step: fill increments if latched mode was shift and fill<POS; out_valid=1 for that cycle if fill (after update) == POS.
- Hold mode: in_ready=0, no state changes, data retained indefinitely.
- mode or in_data changes during a step have no effect on that step.
- Word accepted at step k is at out_data after step k+POS-1 completes.
- Recirculate on a partially filled chain rotates zeros through; fill unchanged.

## Timing
- Reset values: in_ready=1 (if mode≠hold), out_valid=0, fill=0, ph1=ph2=0, out_data=0, head register=0, FSM=IDLE.
- Accept at cycle T: ph1 high T+1; ph2 high T+2+GAP; IDLE (out_valid if full, in_ready again) at T+3+2·GAP.
- in_ready low T+1 .. T+2+2·GAP; back-to-back acceptance possible in the out_valid cycle.
- Throughput: one step per 3+2·GAP cycles.
- rst_n asserted mid-step (any state): immediate abort, all latches and outputs to reset values; first post-reset accept starts a clean step.
- out_data changes only while ph2 high (stage DEPTH-1 is odd); stable in IDLE.

## Test plan
- Reset: WIDTH=8, DEPTH=8, GAP=1; hold rst_n low -> out_data=0x00, fill=0, out_valid=0, ph1=ph2=0, in_ready=1.
- Fill: shift 0x11,0x22,0x33,0x44 back-to-back -> in_ready low 4 cycles after each accept, fill 1..4, out_valid only after 4th step with out_data=0x11.
- Recirculate: after fill, mode=01, four steps -> out_data 0x22,0x33,0x44,0x11, out_valid each step, fill stays 4.
- Hold: mode=10, in_valid=1 for 20 cycles -> in_ready=0, ph1/ph2 stay 0, out_data/fill unchanged; shift 0x55 afterwards -> out_data=0x22.
- Phase timing: GAP=0 and GAP=3, accept at T -> ph1 only at T+1, ph2 at T+2 / T+5, never both high, IDLE at T+3 / T+9.
- Reset mid-step: assert rst_n low during PH2 of 3rd fill step -> all outputs reset; refill 4 words -> first out_valid with out_data = first post-reset word.
